// File: rtl/inst_mem_loader_pkg.sv
// inst_mem_loader_pkg: loader state encodings and instruction memory geometry shared with the fetch-side ROM
package inst_mem_loader_pkg;
    localparam int IMEM_ADDR_W    = 8;
    localparam int IMEM_MAX_WORDS = (2 ** IMEM_ADDR_W) / 4;
    typedef enum logic [2:0] {
        LD_LEN_HI,
        LD_LEN_LO,
        LD_DATA,
        LD_CSUM,
        LD_DONE,
        LD_ERROR
    } ld_state_t;
endpackage

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: writes a framed, XOR-checksummed byte stream into the big-endian instruction memory and holds the CPU until the image is good
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int MAX_WORDS = IMEM_MAX_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    input  logic              reload,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-2:0] words_ld
);
    localparam int CW = ADDR_W + 1;
    ld_state_t         state, state_nx;
    logic [7:0]        len_hi, xsum;
    logic [15:0]       len;
    logic [ADDR_W-2:0] nw;
    logic [CW-1:0]     cnt;
    logic              xfer, restart, last;
    assign len      = {len_hi, in_byte};
    assign in_ready = state != LD_DONE && state != LD_ERROR;
    assign done     = state == LD_DONE;
    assign err      = state == LD_ERROR;
    assign cpu_hold = !done;
    assign xfer     = in_valid & in_ready;
    // reload only has meaning where in_ready is low, so it can never race a byte
    assign restart  = reload & ~in_ready;
    assign last     = (cnt + CW'(1)) == {nw, 2'b00};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= LD_LEN_HI;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        if (restart)
            state_nx = LD_LEN_HI;
        else if (xfer)
            case (state)
                LD_LEN_HI: state_nx = LD_LEN_LO;
                LD_LEN_LO: state_nx = len > 16'(MAX_WORDS) ? LD_ERROR : len == 16'd0 ? LD_CSUM : LD_DATA;
                LD_DATA:   state_nx = last ? LD_CSUM : LD_DATA;
                LD_CSUM:   state_nx = in_byte == xsum ? LD_DONE : LD_ERROR;
                default:   state_nx = state;
            endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            words_ld <= '0;
            len_hi   <= '0;
            nw       <= '0;
            cnt      <= '0;
            xsum     <= '0;
        end else begin
            wr_en <= 1'b0;
            if (restart) begin
                cnt      <= '0;
                xsum     <= '0;
                words_ld <= '0;
            end else if (xfer && state == LD_LEN_HI) begin
                len_hi <= in_byte;
            end else if (xfer && state == LD_LEN_LO) begin
                nw <= len[ADDR_W-2:0];
            end else if (xfer && state == LD_DATA) begin
                wr_en   <= 1'b1;
                wr_addr <= cnt[ADDR_W-1:0];
                wr_data <= in_byte;
                cnt     <= cnt + CW'(1);
                xsum    <= xsum ^ in_byte;
                // word count becomes visible in the same cycle its last byte is written
                if (cnt[1:0] == 2'b11) words_ld <= words_ld + (ADDR_W-1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: table-driven, hand-sequenced and randomized checks of the framed image loader
module tb_inst_mem_loader;
    logic       clk = 1'b0;
    logic       rst_n, in_valid, reload, in_ready, wr_en, cpu_hold, done, err;
    logic [7:0] in_byte, wr_addr, wr_data;
    logic [6:0] words_ld;
    int         total = 0, bad = 0;
    logic [7:0] wa[$], wd[$];

    typedef struct {
        int               n;
        logic [0:11][7:0] b;
        logic             d;
        logic             e;
        int               w;
        int               nwr;
    } vec_t;
    vec_t vt[7];

    always #5 clk = ~clk;

    inst_mem_loader dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
        .reload(reload), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .err(err), .words_ld(words_ld)
    );

    always @(negedge clk)
        if (wr_en) begin
            wa.push_back(wr_addr);
            wd.push_back(wr_data);
        end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int w = 0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_byte  = b;
        while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
        if (w == 20) chk("ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic apply_frame(input logic [7:0] f[$], input int maxgap);
        foreach (f[i]) send(f[i], maxgap == 0 ? 0 : int'($urandom_range(0, maxgap)));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic prep();
        if (done || err) begin
            in_valid = 1'b1;
            in_byte  = 8'hAA;
            reload   = 1'b1;
            @(posedge clk); #1;
            reload   = 1'b0;
            in_valid = 1'b0;
            chk("reload.in_ready", in_ready, 1);
            chk("reload.cpu_hold", cpu_hold, 1);
            chk("reload.done", done, 0);
            chk("reload.err", err, 0);
            chk("reload.words_ld", words_ld, 0);
        end
        wa.delete();
        wd.delete();
    endtask

    task automatic check_result(input string tag, input logic d, input logic e, input int w, input logic [7:0] pay[$]);
        chk({tag, ".done"}, done, d);
        chk({tag, ".err"}, err, e);
        chk({tag, ".cpu_hold"}, cpu_hold, !d);
        chk({tag, ".in_ready"}, in_ready, 0);
        chk({tag, ".words_ld"}, words_ld, w);
        chk({tag, ".nwrites"}, wa.size(), pay.size());
        foreach (pay[i])
            if (i < wa.size()) begin
                chk({tag, ".waddr"}, wa[i], i);
                chk({tag, ".wdata"}, wd[i], pay[i]);
            end
        wa.delete();
        wd.delete();
    endtask

    initial begin
        logic [7:0] f[$], pay[$];
        rst_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00; reload = 1'b0;
        vt[0] = '{n:7,  b:{8'h00, 8'h01, 8'h20, 8'h01, 8'h00, 8'h05, 8'h24, 40'h0}, d:1, e:0, w:1, nwr:4};
        vt[1] = '{n:7,  b:{8'h00, 8'h01, 8'h20, 8'h01, 8'h00, 8'h05, 8'hFF, 40'h0}, d:0, e:1, w:1, nwr:4};
        vt[2] = '{n:2,  b:{8'h00, 8'h41, 80'h0}, d:0, e:1, w:0, nwr:0};
        vt[3] = '{n:3,  b:{8'h00, 8'h00, 8'h00, 72'h0}, d:1, e:0, w:0, nwr:0};
        vt[4] = '{n:3,  b:{8'h00, 8'h00, 8'h01, 72'h0}, d:0, e:1, w:0, nwr:0};
        vt[5] = '{n:11, b:{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88, 8'h00}, d:1, e:0, w:2, nwr:8};
        vt[6] = '{n:2,  b:{8'h01, 8'h00, 80'h0}, d:0, e:1, w:0, nwr:0};
        repeat (2) @(posedge clk);
        #1;
        chk("rst.wr_en", wr_en, 0);
        chk("rst.wr_addr", wr_addr, 0);
        chk("rst.wr_data", wr_data, 0);
        chk("rst.cpu_hold", cpu_hold, 1);
        chk("rst.done", done, 0);
        chk("rst.err", err, 0);
        chk("rst.words_ld", words_ld, 0);
        chk("rst.in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++) begin
            prep();
            f.delete();
            pay.delete();
            for (int i = 0; i < vt[v].n; i++) f.push_back(vt[v].b[i]);
            for (int i = 0; i < vt[v].nwr; i++) pay.push_back(vt[v].b[2+i]);
            apply_frame(f, 0);
            check_result($sformatf("vec%0d", v), vt[v].d, vt[v].e, vt[v].w, pay);
        end

        // asynchronous reset in the middle of a payload, then a fresh image from address 0
        prep();
        f = '{8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC};
        foreach (f[i]) send(f[i], 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.wr_en", wr_en, 0);
        chk("midrst.wr_addr", wr_addr, 0);
        chk("midrst.wr_data", wr_data, 0);
        chk("midrst.cpu_hold", cpu_hold, 1);
        chk("midrst.words_ld", words_ld, 0);
        chk("midrst.in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wa.delete();
        wd.delete();
        f = '{8'h00, 8'h01, 8'h20, 8'h01, 8'h00, 8'h05, 8'h24};
        pay = '{8'h20, 8'h01, 8'h00, 8'h05};
        apply_frame(f, 0);
        check_result("postrst", 1, 0, 1, pay);

        // reload pulse inside DATA must be ignored
        prep();
        f = '{8'h00, 8'h01, 8'hDE, 8'hAD};
        foreach (f[i]) send(f[i], 0);
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        f = '{8'hBE, 8'hEF, 8'h22};
        apply_frame(f, 1);
        pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        check_result("reload_ign", 1, 0, 1, pay);

        // randomized frames against a frame-level model
        for (int k = 0; k < 24; k++) begin
            int n, r;
            logic [7:0] x;
            logic good, over;
            r = int'($urandom_range(0, 9));
            n = r == 0 ? int'($urandom_range(65, 300)) : r == 1 ? 64 : int'($urandom_range(0, 6));
            over = n > 64;
            good = $urandom_range(0, 2) != 0;
            f.delete();
            pay.delete();
            f.push_back(8'(n >> 8));
            f.push_back(8'(n));
            x = 8'h00;
            if (!over) begin
                for (int i = 0; i < 4 * n; i++) begin
                    pay.push_back(8'($urandom));
                    x ^= pay[i];
                    f.push_back(pay[i]);
                end
                f.push_back(good ? x : x ^ 8'(int'($urandom_range(1, 255))));
            end
            prep();
            apply_frame(f, 3);
            check_result($sformatf("rnd%0d", k), !over && good, over || !good, over ? 0 : n, pay);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
